// File: rtl/if_sequencer_if.sv
// Bundle of loader, IM and fetch-control signals around the IF sequencer.
// The sequencer connects through 'master'; loader, IM and pipeline models connect through 'slave'.
interface if_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic [ADDR_W-1:0] im_raddr;
  logic              stall;
  logic              br_taken;
  logic [31:0]       br_target;
  logic              halt_req;
  logic              reload;
  logic [31:0]       pc;
  logic [31:0]       new_pc;
  logic              fetch_valid;
  logic              flush;
  logic              load_err;
  logic [1:0]        state;

  modport master (
    input  ld_valid, ld_data, ld_last, stall, br_taken, br_target, halt_req, reload,
    output ld_ready, im_we, im_waddr, im_wdata, im_raddr, pc, new_pc,
           fetch_valid, flush, load_err, state
  );

  modport slave (
    output ld_valid, ld_data, ld_last, stall, br_taken, br_target, halt_req, reload,
    input  ld_ready, im_we, im_waddr, im_wdata, im_raddr, pc, new_pc,
           fetch_valid, flush, load_err, state
  );
endinterface

// File: rtl/if_sequencer.sv
// Instruction-fetch sequencer: streams a program into IM, then drives the PC.
// Owns the only PC register in the front end.
module if_sequencer #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  if_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    DRAIN = 2'b01,
    RUN   = 2'b10,
    HALT  = 2'b11
  } state_e;

  localparam logic [ADDR_W-1:0] WCNT_MAX = '1;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_waddr_q, im_waddr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              flush_q, flush_d;
  logic              load_err_q, load_err_d;

  logic              accept;
  logic [31:0]       pc_plus4;
  logic [31:0]       redirect_pc;

  assign accept      = bus.ld_valid && (state_q == LOAD);
  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {bus.br_target[31:2], 2'b00};

  assign bus.ld_ready    = (state_q == LOAD);
  assign bus.im_we       = im_we_q;
  assign bus.im_waddr    = im_waddr_q;
  assign bus.im_wdata    = im_wdata_q;
  assign bus.im_raddr    = pc_q[ADDR_W+1:2];
  assign bus.pc          = pc_q;
  assign bus.new_pc      = bus.br_taken ? redirect_pc : pc_plus4;
  assign bus.fetch_valid = (state_q == RUN) && !bus.stall;
  assign bus.flush       = flush_q;
  assign bus.load_err    = load_err_q;
  assign bus.state       = state_q;

  // Next-state logic: load sequencing, drain bubble, PC selection and halt/reload.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wcnt_d     = wcnt_q;
    im_we_d    = 1'b0;
    im_waddr_d = im_waddr_q;
    im_wdata_d = im_wdata_q;
    flush_d    = 1'b0;
    load_err_d = load_err_q;

    case (state_q)
      LOAD: begin
        pc_d = RESET_PC;
        if (accept) begin
          im_we_d    = 1'b1;
          im_waddr_d = wcnt_q;
          im_wdata_d = bus.ld_data;
          wcnt_d     = wcnt_q + ADDR_W'(1);
          if (bus.ld_last) begin
            state_d = DRAIN;
          end else if (wcnt_q == WCNT_MAX) begin
            load_err_d = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (bus.br_taken) begin
          pc_d    = redirect_pc;
          flush_d = 1'b1;
        end else if (!bus.stall) begin
          pc_d = pc_plus4;
        end
      end
      HALT: begin
        if (bus.reload) begin
          state_d    = LOAD;
          pc_d       = RESET_PC;
          wcnt_d     = '0;
          load_err_d = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOAD;
      pc_q       <= RESET_PC;
      wcnt_q     <= '0;
      im_we_q    <= 1'b0;
      im_waddr_q <= '0;
      im_wdata_q <= '0;
      flush_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wcnt_q     <= wcnt_d;
      im_we_q    <= im_we_d;
      im_waddr_q <= im_waddr_d;
      im_wdata_q <= im_wdata_d;
      flush_q    <= flush_d;
      load_err_q <= load_err_d;
    end
  end

endmodule
